// File: rtl/my_gate_pkg.sv
// -----------------------------------------------------------------------------
// my_gate_pkg
// Shared types for the gate-reduction sequencer:
//   red_op_t    - reduction requested by the client (AND/OR/XOR/NOR)
//   gate_op_t   - opcode presented to the external 2-input gate unit
//   state_t     - sequencer FSM states
//   red_to_gate - maps a reduction onto the gate opcode that implements it
// -----------------------------------------------------------------------------
package my_gate_pkg;

  typedef enum logic [1:0] {
    R_AND = 2'b00,
    R_OR  = 2'b01,
    R_XOR = 2'b10,
    R_NOR = 2'b11
  } red_op_t;

  typedef enum logic [1:0] {
    G_AND = 2'b00,
    G_OR  = 2'b01,
    G_XOR = 2'b10
  } gate_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  // Width of the per-evaluation hold counter (OP_LAT is at most 15).
  localparam int TIMER_W = 4;

  // NOR is evaluated as an OR chain; the final inversion happens at DONE.
  function automatic gate_op_t red_to_gate(input red_op_t r);
    gate_op_t g;
    case (r)
      R_AND:   g = G_AND;
      R_OR:    g = G_OR;
      R_XOR:   g = G_XOR;
      R_NOR:   g = G_OR;
      default: g = G_AND;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/my_gate_step_timer.sv
// -----------------------------------------------------------------------------
// my_gate_step_timer
// Countdown that holds the gate inputs stable for OP_LAT cycles per evaluation.
// Loaded with OP_LAT-1 when an evaluation starts, decremented while waiting;
// 'zero' marks the cycle whose closing edge samples the gate output.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset
//   load   in  reload counter with OP_LAT-1
//   dec    in  decrement (ignored at zero)
//   zero   out counter is zero
// -----------------------------------------------------------------------------
module my_gate_step_timer #(
  parameter int OP_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);
  import my_gate_pkg::*;

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(OP_LAT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LOAD_VAL;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/my_gate_seq.sv
// -----------------------------------------------------------------------------
// my_gate_seq
// Computes an N-bit reduction (AND/OR/XOR/NOR) of 'din' by chaining WIDTH-1
// evaluations of one external 2-input gate unit through a 1-bit accumulator.
// Each evaluation holds the gate inputs for 1+OP_LAT cycles before sampling.
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start, op, din  request; accepted only in IDLE, op/din captured then
//   busy            high from the cycle after accept through DONE
//   done            one-cycle pulse, result valid in that cycle
//   result          reduction result, held until the next done
//   gate_op/a/b     drive the external gate unit (all zero in IDLE/DONE)
//   gate_y          gate unit output, sampled only at evaluation end
//   op_count        (GATE_OPCNT_EN only) saturating count of gate samples
// Build option: define GATE_OPCNT_EN to add op_count.
// -----------------------------------------------------------------------------
module my_gate_seq #(
  parameter int WIDTH  = 8,
  parameter int OP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [1:0]       gate_op,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y
`ifdef GATE_OPCNT_EN
  ,
  output logic [31:0]      op_count
`endif
);
  import my_gate_pkg::*;

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_din;
  red_op_t          r_op;
  logic             r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_result;

  logic w_capture;
  logic w_sample;
  logic w_tmr_load;
  logic w_tmr_dec;
  logic w_tmr_zero;
  logic w_last;
  logic w_final;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_final = r_acc ^ (r_op == R_NOR);

  // Hold timer only exists when there is something to wait for.
  generate
    if (OP_LAT > 0) begin : g_timer
      my_gate_step_timer #(.OP_LAT(OP_LAT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_tmr_load),
        .dec   (w_tmr_dec),
        .zero  (w_tmr_zero)
      );
    end else begin : g_no_timer
      logic w_unused_tmr;
      assign w_unused_tmr = w_tmr_load | w_tmr_dec;
      assign w_tmr_zero   = 1'b1;
    end
  endgenerate

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_sample   = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_dec  = 1'b0;
    gate_op    = G_AND;
    gate_a     = 1'b0;
    gate_b     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = (WIDTH == 1) ? DONE : EVAL;
        end
      end

      EVAL: begin
        gate_op = red_to_gate(r_op);
        gate_a  = r_acc;
        gate_b  = r_din[r_idx];
        if (OP_LAT == 0) begin
          w_sample = 1'b1;
          w_next   = w_last ? DONE : EVAL;
        end else begin
          w_tmr_load = 1'b1;
          w_next     = WAIT;
        end
      end

      WAIT: begin
        gate_op = red_to_gate(r_op);
        gate_a  = r_acc;
        gate_b  = r_din[r_idx];
        if (w_tmr_zero) begin
          w_sample = 1'b1;
          w_next   = w_last ? DONE : EVAL;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_din    <= '0;
      r_op     <= R_AND;
      r_acc    <= 1'b0;
      r_idx    <= '0;
      r_result <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      r_state <= w_next;
      if (w_capture) begin
        r_din <= din;
        r_op  <= red_op_t'(op);
        r_acc <= din[0];
        r_idx <= IDX_W'(1);
      end else if (w_sample) begin
        r_acc <= gate_y;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
      if (r_state == DONE) r_result <= w_final;
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  // Result is live during DONE and latched afterwards so it holds until the next done.
  assign result = (r_state == DONE) ? w_final : r_result;

`ifdef GATE_OPCNT_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_sample && (r_op_count != 32'hFFFF_FFFF)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_my_gate_seq.sv
// -----------------------------------------------------------------------------
// tb_my_gate_seq
// Scoreboard bench for my_gate_seq (WIDTH=8, OP_LAT=1) plus a WIDTH=1 instance.
// A posedge model decides which starts are accepted and queues the expected
// result and done time from plain reduction arithmetic; a negedge monitor
// compares whenever done is presented, and checks busy, result hold and the
// gate-unit drive against the evaluation schedule.
// -----------------------------------------------------------------------------
module tb_my_gate_seq;

  localparam int W    = 8;
  localparam int L    = 1;
  localparam int STEP = L + 1;
  localparam int LAT  = 1 + (W - 1) * STEP;  // cycle of done after accept

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] din;
  logic         busy, done, result;
  logic [1:0]   gate_op;
  logic         gate_a, gate_b;
  logic         gate_y;
`ifdef GATE_OPCNT_EN
  logic [31:0]  op_count;
  logic [31:0]  s1_op_count;
`endif

  logic       s1_start;
  logic [1:0] s1_op;
  logic [0:0] s1_din;
  logic       s1_busy, s1_done, s1_result;
  logic [1:0] s1_gate_op;
  logic       s1_gate_a, s1_gate_b;
  logic       s1_gate_y;

  my_gate_seq #(.WIDTH(W), .OP_LAT(L)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .gate_op  (gate_op),
    .gate_a   (gate_a),
    .gate_b   (gate_b),
    .gate_y   (gate_y)
`ifdef GATE_OPCNT_EN
    ,
    .op_count (op_count)
`endif
  );

  my_gate_seq #(.WIDTH(1), .OP_LAT(0)) u_w1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s1_start),
    .op       (s1_op),
    .din      (s1_din),
    .busy     (s1_busy),
    .done     (s1_done),
    .result   (s1_result),
    .gate_op  (s1_gate_op),
    .gate_a   (s1_gate_a),
    .gate_b   (s1_gate_b),
    .gate_y   (s1_gate_y)
`ifdef GATE_OPCNT_EN
    ,
    .op_count (s1_op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External gate unit: one-cycle registered 2-input gate.
  function automatic logic gfun(input logic [1:0] g, input logic a, input logic b);
    case (g)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) gate_y <= gfun(gate_op, gate_a, gate_b);
  assign s1_gate_y = 1'b0;

  // Reference: whole-word reductions.
  function automatic logic ref_reduce(input logic [1:0] o, input logic [W-1:0] d);
    case (o)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~|d;
    endcase
  endfunction

  function automatic logic [1:0] gate_code(input logic [1:0] o);
    return (o == 2'b11) ? 2'b01 : o;
  endfunction

  // Partial reduction of bits [0..n-1] -- the accumulator value while bit n is presented.
  function automatic logic partial(input logic [1:0] o, input logic [W-1:0] d, input int n);
    logic a;
    a = d[0];
    for (int j = 1; j < n; j++) a = gfun(gate_code(o), a, d[j]);
    return a;
  endfunction

  typedef struct {
    logic res;
    int   done_edge;
  } exp_t;

  exp_t         sb[$];
  int           edge_n     = 0;
  int           model_free = 0;
  bit           have_op    = 1'b0;
  int           cur_e      = 0;
  logic [W-1:0] cur_din    = '0;
  logic [1:0]   cur_op     = '0;
  logic         last_res   = 1'b0;
  logic [31:0]  cnt_model  = '0;

  // Acceptance model: one request in flight; a start is taken at an edge only
  // once the previous request's DONE cycle has passed.
  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    if (!rst_n) begin
      sb.delete();
      have_op    = 1'b0;
      model_free = edge_n + 1;
      last_res   = 1'b0;
      cnt_model  = '0;
    end else if (start && edge_n >= model_free) begin
      e.res       = ref_reduce(op, din);
      e.done_edge = edge_n + LAT - 1;
      sb.push_back(e);
      have_op    = 1'b1;
      cur_e      = edge_n;
      cur_din    = din;
      cur_op     = op;
      model_free = edge_n + LAT + 1;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    int   idx;
    rel = edge_n - cur_e;
    check("busy", busy, (have_op && rel >= 0 && rel <= LAT - 1));
    if (have_op && rel >= 0 && rel < (W - 1) * STEP) begin
      idx = 1 + rel / STEP;
      check("gate_b", gate_b, cur_din[idx]);
      check("gate_a", gate_a, partial(cur_op, cur_din, idx));
      check("gate_op", gate_op, gate_code(cur_op));
    end else begin
      check("gate_idle", {gate_op, gate_a, gate_b}, 4'b0000);
    end

    while (sb.size() > 0 && sb[0].done_edge < edge_n) begin
      e = sb.pop_front();
      check("done_missing_at_edge", edge_n, e.done_edge);
    end

    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        check("done_edge", edge_n, e.done_edge);
        check("result", result, e.res);
        last_res  = e.res;
        cnt_model = cnt_model + (W - 1);
`ifdef GATE_OPCNT_EN
        check("op_count", op_count, cnt_model);
`endif
      end
    end else begin
      check("result_hold", result, last_res);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] d);
    start = 1'b1;
    op    = o;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    din   = W'($urandom);
    repeat (LAT) @(negedge clk);
  endtask

  task automatic run_w1(input logic [1:0] o, input logic d, input logic exp);
    s1_start = 1'b1;
    s1_op    = o;
    s1_din   = d;
    @(negedge clk);
    s1_start = 1'b0;
    s1_din   = ~d;
    check("w1_done", s1_done, 1'b1);
    check("w1_result", s1_result, exp);
    check("w1_busy_done", s1_busy, 1'b1);
    @(negedge clk);
    check("w1_done_drop", s1_done, 1'b0);
    check("w1_idle", s1_busy, 1'b0);
    check("w1_hold", s1_result, exp);
`ifdef GATE_OPCNT_EN
    check("w1_op_count", s1_op_count, 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    din      = '0;
    s1_start = 1'b0;
    s1_op    = 2'b00;
    s1_din   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 1'b0);
`ifdef GATE_OPCNT_EN
    check("rst_op_count", op_count, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed reductions.
    run_op(2'b00, 8'hFF);
    run_op(2'b00, 8'hFE);
    run_op(2'b01, 8'h00);
    run_op(2'b01, 8'h80);
    run_op(2'b11, 8'h00);
    run_op(2'b11, 8'h80);
    run_op(2'b10, 8'hA5);
    run_op(2'b10, 8'h07);

    // Starts during busy (cycles 3 and 15) are dropped; the one right after DONE is taken.
    for (int k = 0; k <= 16; k++) begin
      start = (k == 0 || k == 3 || k == 15 || k == 16);
      op    = 2'($urandom);
      din   = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // Reset mid-operation, then a clean op.
    start = 1'b1;
    op    = 2'b10;
    din   = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 1'b0);
`ifdef GATE_OPCNT_EN
    check("abort_op_count", op_count, 32'd0);
`endif
    run_op(2'b01, 8'h10);

    // WIDTH=1: done in the cycle after accept.
    run_w1(2'b00, 1'b1, 1'b1);
    run_w1(2'b01, 1'b0, 1'b0);
    run_w1(2'b10, 1'b1, 1'b1);
    run_w1(2'b11, 1'b0, 1'b1);

    // Random traffic: sporadic starts (many while busy), drifting inputs, rare resets.
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      din   = W'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
